// File: rtl/csr_file.sv
// Machine-mode CSR file: status, trap, interrupt-enable and 64-bit counter registers.
// Reads are combinational from csr_ra. Writes, traps and counter updates happen on the rising clk edge.
module csr_file #(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CSR_ADDR_W-1:0] csr_ra,
    output logic [XLEN-1:0]       csr_rd,
    input  logic [CSR_ADDR_W-1:0] csr_wa,
    input  logic                  csr_we,
    input  logic [XLEN-1:0]       csr_wd,
    output logic                  csr_err,
    input  logic                  retire,
    input  logic                  trap,
    input  logic [XLEN-1:0]       trap_cause,
    input  logic [XLEN-1:0]       trap_pc,
    input  logic [XLEN-1:0]       trap_val,
    input  logic                  mret,
    input  logic                  irq_ext,
    output logic [XLEN-1:0]       mtvec_o,
    output logic [XLEN-1:0]       mepc_o,
    output logic                  irq_pending
);

    localparam logic [CSR_ADDR_W-1:0] A_MSTATUS   = CSR_ADDR_W'(12'h300);
    localparam logic [CSR_ADDR_W-1:0] A_MISA      = CSR_ADDR_W'(12'h301);
    localparam logic [CSR_ADDR_W-1:0] A_MIE       = CSR_ADDR_W'(12'h304);
    localparam logic [CSR_ADDR_W-1:0] A_MTVEC     = CSR_ADDR_W'(12'h305);
    localparam logic [CSR_ADDR_W-1:0] A_MSCRATCH  = CSR_ADDR_W'(12'h340);
    localparam logic [CSR_ADDR_W-1:0] A_MEPC      = CSR_ADDR_W'(12'h341);
    localparam logic [CSR_ADDR_W-1:0] A_MCAUSE    = CSR_ADDR_W'(12'h342);
    localparam logic [CSR_ADDR_W-1:0] A_MTVAL     = CSR_ADDR_W'(12'h343);
    localparam logic [CSR_ADDR_W-1:0] A_MIP       = CSR_ADDR_W'(12'h344);
    localparam logic [CSR_ADDR_W-1:0] A_MCYCLE    = CSR_ADDR_W'(12'hB00);
    localparam logic [CSR_ADDR_W-1:0] A_MINSTRET  = CSR_ADDR_W'(12'hB02);
    localparam logic [CSR_ADDR_W-1:0] A_MCYCLEH   = CSR_ADDR_W'(12'hB80);
    localparam logic [CSR_ADDR_W-1:0] A_MINSTRETH = CSR_ADDR_W'(12'hB82);
    localparam logic [CSR_ADDR_W-1:0] A_CYCLE     = CSR_ADDR_W'(12'hC00);
    localparam logic [CSR_ADDR_W-1:0] A_INSTRET   = CSR_ADDR_W'(12'hC02);
    localparam logic [CSR_ADDR_W-1:0] A_CYCLEH    = CSR_ADDR_W'(12'hC80);
    localparam logic [CSR_ADDR_W-1:0] A_INSTRETH  = CSR_ADDR_W'(12'hC82);
    localparam logic [CSR_ADDR_W-1:0] A_MVENDORID = CSR_ADDR_W'(12'hF11);
    localparam logic [CSR_ADDR_W-1:0] A_MARCHID   = CSR_ADDR_W'(12'hF12);
    localparam logic [CSR_ADDR_W-1:0] A_MIMPID    = CSR_ADDR_W'(12'hF13);
    localparam logic [CSR_ADDR_W-1:0] A_MHARTID   = CSR_ADDR_W'(12'hF14);

    localparam logic [XLEN-1:0] MISA_VAL = XLEN'(32'h4000_0100);

    logic            status_mie;
    logic            status_mpie;
    logic            mie_msie;
    logic            mie_mtie;
    logic            mie_meie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic [XLEN-1:0] mcycle_lo;
    logic [XLEN-1:0] mcycle_hi;
    logic [XLEN-1:0] minstret_lo;
    logic [XLEN-1:0] minstret_hi;

    logic [XLEN-1:0]   mstatus_val;
    logic [XLEN-1:0]   mie_val;
    logic [XLEN-1:0]   mip_val;
    logic [XLEN-1:0]   rd_val;
    logic              wr_err;
    logic              wr_ok;
    logic [2*XLEN-1:0] mcycle_nxt;
    logic [2*XLEN-1:0] minstret_nxt;

    function automatic logic is_impl(input logic [CSR_ADDR_W-1:0] a);
        case (a)
            A_MSTATUS, A_MISA, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MTVAL, A_MIP, A_MCYCLE, A_MINSTRET, A_MCYCLEH, A_MINSTRETH,
            A_CYCLE, A_INSTRET, A_CYCLEH, A_INSTRETH, A_MVENDORID, A_MARCHID,
            A_MIMPID, A_MHARTID: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    // Writing one half suppresses its own increment; the other half still sees the carry.
    function automatic logic [2*XLEN-1:0] cnt_next(
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo,
        input logic            inc,
        input logic            wr_lo,
        input logic            wr_hi,
        input logic [XLEN-1:0] wd
    );
        logic carry;
        carry = inc & (&lo);
        if (wr_lo)
            return {hi + XLEN'(carry), wd};
        else if (wr_hi)
            return {wd, lo + XLEN'(inc)};
        else
            return {hi, lo} + (2*XLEN)'(inc);
    endfunction

    always_comb begin
        mstatus_val     = '0;
        mstatus_val[12] = 1'b1;
        mstatus_val[11] = 1'b1;
        mstatus_val[7]  = status_mpie;
        mstatus_val[3]  = status_mie;
        mie_val         = '0;
        mie_val[11]     = mie_meie;
        mie_val[7]      = mie_mtie;
        mie_val[3]      = mie_msie;
        mip_val         = '0;
        mip_val[11]     = irq_ext;
    end

    always_comb begin
        rd_val = '0;
        case (csr_ra)
            A_MSTATUS:              rd_val = mstatus_val;
            A_MISA:                 rd_val = MISA_VAL;
            A_MIE:                  rd_val = mie_val;
            A_MTVEC:                rd_val = mtvec;
            A_MSCRATCH:             rd_val = mscratch;
            A_MEPC:                 rd_val = mepc;
            A_MCAUSE:               rd_val = mcause;
            A_MTVAL:                rd_val = mtval;
            A_MIP:                  rd_val = mip_val;
            A_MCYCLE, A_CYCLE:      rd_val = mcycle_lo;
            A_MCYCLEH, A_CYCLEH:    rd_val = mcycle_hi;
            A_MINSTRET, A_INSTRET:  rd_val = minstret_lo;
            A_MINSTRETH, A_INSTRETH: rd_val = minstret_hi;
            default:                rd_val = '0;
        endcase
    end

    assign csr_rd = rd_val;

    // Read-only space (top address bits 11) and the read-only machine CSRs reject writes.
    assign wr_err = csr_we & (~is_impl(csr_wa)
                              | (csr_wa[CSR_ADDR_W-1:CSR_ADDR_W-2] == 2'b11)
                              | (csr_wa == A_MISA)
                              | (csr_wa == A_MIP));
    assign wr_ok   = csr_we & ~wr_err;
    assign csr_err = ((csr_ra != '0) & ~is_impl(csr_ra)) | wr_err;

    assign mcycle_nxt   = cnt_next(mcycle_hi, mcycle_lo, 1'b1,
                                   wr_ok & (csr_wa == A_MCYCLE),
                                   wr_ok & (csr_wa == A_MCYCLEH), csr_wd);
    assign minstret_nxt = cnt_next(minstret_hi, minstret_lo, retire,
                                   wr_ok & (csr_wa == A_MINSTRET),
                                   wr_ok & (csr_wa == A_MINSTRETH), csr_wd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_lo   <= '0;
            mcycle_hi   <= '0;
            minstret_lo <= '0;
            minstret_hi <= '0;
        end else begin
            {mcycle_hi, mcycle_lo}     <= mcycle_nxt;
            {minstret_hi, minstret_lo} <= minstret_nxt;
        end
    end

    // Trap outranks mret, and both outrank a software write to the fields they own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            mie_msie    <= 1'b0;
            mie_mtie    <= 1'b0;
            mie_meie    <= 1'b0;
            mtvec       <= '0;
            mscratch    <= '0;
            mepc        <= '0;
            mcause      <= '0;
            mtval       <= '0;
        end else begin
            if (trap) begin
                status_mpie <= status_mie;
                status_mie  <= 1'b0;
            end else if (mret) begin
                status_mie  <= status_mpie;
                status_mpie <= 1'b1;
            end else if (wr_ok && csr_wa == A_MSTATUS) begin
                status_mie  <= csr_wd[3];
                status_mpie <= csr_wd[7];
            end

            if (trap) begin
                mepc   <= {trap_pc[XLEN-1:2], 2'b00};
                mcause <= trap_cause;
                mtval  <= trap_val;
            end else if (wr_ok) begin
                if (csr_wa == A_MEPC)   mepc   <= {csr_wd[XLEN-1:2], 2'b00};
                if (csr_wa == A_MCAUSE) mcause <= csr_wd;
                if (csr_wa == A_MTVAL)  mtval  <= csr_wd;
            end

            if (wr_ok && csr_wa == A_MIE) begin
                mie_msie <= csr_wd[3];
                mie_mtie <= csr_wd[7];
                mie_meie <= csr_wd[11];
            end
            if (wr_ok && csr_wa == A_MTVEC)    mtvec    <= {csr_wd[XLEN-1:2], 2'b00};
            if (wr_ok && csr_wa == A_MSCRATCH) mscratch <= csr_wd;
        end
    end

    assign mtvec_o     = mtvec;
    assign mepc_o      = mepc;
    assign irq_pending = status_mie & mie_meie & irq_ext;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file: reset, register masks, counters, traps, interrupts.
`timescale 1ns/1ps
module tb_csr_file;

    logic        clk;
    logic        rst_n;
    logic [11:0] csr_ra;
    logic [31:0] csr_rd;
    logic [11:0] csr_wa;
    logic        csr_we;
    logic [31:0] csr_wd;
    logic        csr_err;
    logic        retire;
    logic        trap;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret;
    logic        irq_ext;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        irq_pending;

    int checks;
    int errors;

    csr_file #(.XLEN(32), .CSR_ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_ra(csr_ra), .csr_rd(csr_rd),
        .csr_wa(csr_wa), .csr_we(csr_we), .csr_wd(csr_wd),
        .csr_err(csr_err), .retire(retire),
        .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
        .mret(mret), .irq_ext(irq_ext),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .irq_pending(irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_wa = a;
        csr_wd = d;
        csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic look(input logic [11:0] a);
        csr_ra = a;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        csr_ra = 12'h000;
        #1;
        checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL rst_rd got %h exp %h", csr_rd, 32'h0); end
        checks++; if (csr_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", csr_err); end
        checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq_pending); end
        checks++; if (mtvec_o !== 32'h0) begin errors++; $display("FAIL rst_mtvec got %h exp 0", mtvec_o); end
        checks++; if (mepc_o !== 32'h0) begin errors++; $display("FAIL rst_mepc got %h exp 0", mepc_o); end
        look(12'h300);
        checks++; if (csr_rd !== 32'h0000_1800) begin errors++; $display("FAIL rst_mstatus got %h exp %h", csr_rd, 32'h1800); end
        tick();
        tick();
        look(12'hB00);
        checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL rst_hold_mcycle got %h exp 0", csr_rd); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (csr_rd !== 32'h1) begin errors++; $display("FAIL first_count got %h exp 1", csr_rd); end
        look(12'h301);
        checks++; if (csr_rd !== 32'h4000_0100) begin errors++; $display("FAIL misa got %h exp %h", csr_rd, 32'h40000100); end
    endtask

    task automatic test_scratch();
        csr_ra = 12'h000;
        csr_wa = 12'h340;
        csr_wd = 32'hDEAD_BEEF;
        csr_we = 1'b1;
        #1;
        checks++; if (csr_err !== 1'b0) begin errors++; $display("FAIL scratch_wr_err got %b exp 0", csr_err); end
        tick();
        csr_we = 1'b0;
        look(12'h340);
        checks++; if (csr_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL scratch_rd got %h exp %h", csr_rd, 32'hDEADBEEF); end
        checks++; if (csr_err !== 1'b0) begin errors++; $display("FAIL scratch_rd_err got %b exp 0", csr_err); end
    endtask

    task automatic test_masks();
        csr_ra = 12'h000;
        wr(12'h305, 32'hFFFF_FFFF);
        look(12'h305);
        checks++; if (csr_rd !== 32'hFFFF_FFFC) begin errors++; $display("FAIL mtvec_rd got %h exp %h", csr_rd, 32'hFFFFFFFC); end
        checks++; if (mtvec_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL mtvec_o got %h exp %h", mtvec_o, 32'hFFFFFFFC); end
        wr(12'h341, 32'h1234_5677);
        checks++; if (mepc_o !== 32'h1234_5674) begin errors++; $display("FAIL mepc_mask got %h exp %h", mepc_o, 32'h12345674); end
        wr(12'h304, 32'hFFFF_FFFF);
        look(12'h304);
        checks++; if (csr_rd !== 32'h0000_0888) begin errors++; $display("FAIL mie_mask got %h exp %h", csr_rd, 32'h888); end
        wr(12'h300, 32'hFFFF_FFFF);
        look(12'h300);
        checks++; if (csr_rd !== 32'h0000_1888) begin errors++; $display("FAIL mstatus_mask got %h exp %h", csr_rd, 32'h1888); end
        wr(12'h300, 32'h0);
        wr(12'h304, 32'h0);
        // Shadow write must error and leave mcycle counting normally.
        wr(12'hB00, 32'd100);
        look(12'hB00);
        csr_wa = 12'hC00;
        csr_wd = 32'h0;
        csr_we = 1'b1;
        #1;
        checks++; if (csr_err !== 1'b1) begin errors++; $display("FAIL shadow_wr_err got %b exp 1", csr_err); end
        tick();
        csr_we = 1'b0;
        checks++; if (csr_rd !== 32'd101) begin errors++; $display("FAIL shadow_wr_cnt got %0d exp 101", csr_rd); end
    endtask

    task automatic test_errors();
        look(12'h123);
        checks++; if (csr_err !== 1'b1) begin errors++; $display("FAIL rd_unimpl got %b exp 1", csr_err); end
        look(12'h000);
        checks++; if (csr_err !== 1'b0 || csr_rd !== 32'h0) begin errors++; $display("FAIL rd_idle got %b/%h exp 0/0", csr_err, csr_rd); end
        look(12'hF14);
        checks++; if (csr_err !== 1'b0 || csr_rd !== 32'h0) begin errors++; $display("FAIL rd_hartid got %b/%h exp 0/0", csr_err, csr_rd); end
        csr_ra = 12'h000;
        csr_wa = 12'h301;
        csr_wd = 32'h0;
        csr_we = 1'b1;
        #1;
        checks++; if (csr_err !== 1'b1) begin errors++; $display("FAIL wr_misa_err got %b exp 1", csr_err); end
        tick();
        csr_we = 1'b0;
        look(12'h301);
        checks++; if (csr_rd !== 32'h4000_0100) begin errors++; $display("FAIL misa_kept got %h exp %h", csr_rd, 32'h40000100); end
        csr_ra = 12'h000;
        csr_wa = 12'h344;
        csr_we = 1'b1;
        #1;
        checks++; if (csr_err !== 1'b1) begin errors++; $display("FAIL wr_mip_err got %b exp 1", csr_err); end
        csr_wa = 12'hF11;
        #1;
        checks++; if (csr_err !== 1'b1) begin errors++; $display("FAIL wr_f11_err got %b exp 1", csr_err); end
        csr_wa = 12'h3A0;
        #1;
        checks++; if (csr_err !== 1'b1) begin errors++; $display("FAIL wr_unimpl_err got %b exp 1", csr_err); end
        csr_we = 1'b0;
        #1;
        checks++; if (csr_err !== 1'b0) begin errors++; $display("FAIL wr_idle_err got %b exp 0", csr_err); end
    endtask

    task automatic test_counters();
        csr_ra = 12'h000;
        wr(12'hB00, 32'hFFFF_FFFE);
        wr(12'hB80, 32'd5);
        tick();
        look(12'hB00);
        checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL mcycle_carry_lo got %h exp 0", csr_rd); end
        look(12'hB80);
        checks++; if (csr_rd !== 32'd6) begin errors++; $display("FAIL mcycle_carry_hi got %h exp 6", csr_rd); end
        look(12'hC80);
        checks++; if (csr_rd !== 32'd6) begin errors++; $display("FAIL cycleh_shadow got %h exp 6", csr_rd); end
        csr_ra = 12'h000;
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        look(12'hB00);
        checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL wrap_lo got %h exp 0", csr_rd); end
        look(12'hB80);
        checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL wrap_hi got %h exp 0", csr_rd); end
        csr_ra = 12'h000;
        retire = 1'b0;
        wr(12'hB02, 32'hFFFF_FFFF);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        look(12'hB02);
        checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL instret_lo got %h exp 0", csr_rd); end
        look(12'hB82);
        checks++; if (csr_rd !== 32'h1) begin errors++; $display("FAIL instret_hi got %h exp 1", csr_rd); end
        tick();
        tick();
        look(12'hC02);
        checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL instret_idle got %h exp 0", csr_rd); end
        look(12'hC82);
        checks++; if (csr_rd !== 32'h1) begin errors++; $display("FAIL instreth_shadow got %h exp 1", csr_rd); end
    endtask

    task automatic test_trap();
        csr_ra = 12'h000;
        wr(12'h300, 32'h0000_0008);
        look(12'h300);
        checks++; if (csr_rd !== 32'h0000_1808) begin errors++; $display("FAIL mie_set got %h exp %h", csr_rd, 32'h1808); end
        trap = 1'b1;
        trap_pc = 32'h0000_1003;
        trap_cause = 32'h8000_000B;
        trap_val = 32'h0000_0055;
        wr(12'h342, 32'h0000_1234);
        trap = 1'b0;
        checks++; if (mepc_o !== 32'h0000_1000) begin errors++; $display("FAIL trap_mepc got %h exp %h", mepc_o, 32'h1000); end
        look(12'h300);
        checks++; if (csr_rd !== 32'h0000_1880) begin errors++; $display("FAIL trap_mstatus got %h exp %h", csr_rd, 32'h1880); end
        look(12'h342);
        checks++; if (csr_rd !== 32'h8000_000B) begin errors++; $display("FAIL trap_mcause got %h exp %h", csr_rd, 32'h8000000B); end
        look(12'h343);
        checks++; if (csr_rd !== 32'h0000_0055) begin errors++; $display("FAIL trap_mtval got %h exp %h", csr_rd, 32'h55); end
        mret = 1'b1;
        wr(12'h341, 32'h0000_2000);
        mret = 1'b0;
        look(12'h300);
        checks++; if (csr_rd !== 32'h0000_1888) begin errors++; $display("FAIL mret_mstatus got %h exp %h", csr_rd, 32'h1888); end
        checks++; if (mepc_o !== 32'h0000_2000) begin errors++; $display("FAIL mret_mepc_wr got %h exp %h", mepc_o, 32'h2000); end
        trap = 1'b1;
        mret = 1'b1;
        trap_pc = 32'h0000_2FFF;
        tick();
        trap = 1'b0;
        mret = 1'b0;
        checks++; if (csr_rd !== 32'h0000_1880) begin errors++; $display("FAIL trap_over_mret got %h exp %h", csr_rd, 32'h1880); end
        checks++; if (mepc_o !== 32'h0000_2FFC) begin errors++; $display("FAIL trap_over_mret_pc got %h exp %h", mepc_o, 32'h2FFC); end
        mret = 1'b1;
        wr(12'h300, 32'h0);
        mret = 1'b0;
        checks++; if (csr_rd !== 32'h0000_1888) begin errors++; $display("FAIL mret_over_wr got %h exp %h", csr_rd, 32'h1888); end
    endtask

    task automatic test_irq();
        csr_ra = 12'h000;
        wr(12'h304, 32'h0000_0800);
        wr(12'h300, 32'h0000_0008);
        irq_ext = 1'b1;
        #1;
        checks++; if (irq_pending !== 1'b1) begin errors++; $display("FAIL irq_on got %b exp 1", irq_pending); end
        look(12'h344);
        checks++; if (csr_rd !== 32'h0000_0800) begin errors++; $display("FAIL mip_rd got %h exp %h", csr_rd, 32'h800); end
        csr_ra = 12'h000;
        wr(12'h300, 32'h0);
        checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL irq_mie_off got %b exp 0", irq_pending); end
        wr(12'h300, 32'h0000_0008);
        irq_ext = 1'b0;
        #1;
        checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL irq_line_off got %b exp 0", irq_pending); end
    endtask

    task automatic test_reset_mid();
        csr_ra = 12'h000;
        wr(12'h340, 32'hA5A5_A5A5);
        retire = 1'b1;
        tick();
        tick();
        csr_wa = 12'h340;
        csr_wd = 32'h0000_0077;
        csr_we = 1'b1;
        trap = 1'b1;
        trap_pc = 32'h0000_4000;
        csr_ra = 12'hB00;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL mid_mcycle got %h exp 0", csr_rd); end
        look(12'hB02);
        checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL mid_minstret got %h exp 0", csr_rd); end
        look(12'h340);
        checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL mid_mscratch got %h exp 0", csr_rd); end
        checks++; if (csr_err !== 1'b0) begin errors++; $display("FAIL mid_err got %b exp 0", csr_err); end
        @(posedge clk);
        #1;
        csr_we = 1'b0;
        trap = 1'b0;
        retire = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        look(12'h340);
        checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL post_mscratch got %h exp 0", csr_rd); end
        checks++; if (mepc_o !== 32'h0) begin errors++; $display("FAIL post_mepc got %h exp 0", mepc_o); end
        look(12'hB00);
        checks++; if (csr_rd !== 32'h1) begin errors++; $display("FAIL post_mcycle got %h exp 1", csr_rd); end
        look(12'h300);
        checks++; if (csr_rd !== 32'h0000_1800) begin errors++; $display("FAIL post_mstatus got %h exp %h", csr_rd, 32'h1800); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        csr_ra = '0;
        csr_wa = '0;
        csr_we = 1'b0;
        csr_wd = '0;
        retire = 1'b0;
        trap = 1'b0;
        trap_cause = '0;
        trap_pc = '0;
        trap_val = '0;
        mret = 1'b0;
        irq_ext = 1'b0;
        test_reset();
        test_scratch();
        test_masks();
        test_errors();
        test_counters();
        test_trap();
        test_irq();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width.
REQ-002 The block SHALL have parameter CSR_ADDR_W, default 12, meaning CSR address width.
REQ-003 The block SHALL have port clk  in  1  clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port csr_ra  in  CSR_ADDR_W  read address.
REQ-006 The block SHALL have port csr_rd  out  XLEN  read data, combinational from csr_ra.
REQ-007 The block SHALL have ports csr_wa  in  CSR_ADDR_W, csr_we  in  1, and csr_wd  in  XLEN for the write address, write enable and write data.
REQ-008 The block SHALL have port csr_err  out  1  access error, combinational.
REQ-009 The block SHALL have port retire  in  1  one instruction retired this cycle.
REQ-010 The block SHALL have ports trap  in  1, trap_cause  in  XLEN, trap_pc  in  XLEN, and trap_val  in  XLEN for trap entry.
REQ-011 The block SHALL have port mret  in  1  trap return.
REQ-012 The block SHALL have port irq_ext  in  1  external interrupt line.
REQ-013 The block SHALL have ports mtvec_o  out  XLEN and mepc_o  out  XLEN for the current mtvec and mepc values.
REQ-014 The block SHALL have port irq_pending  out  1  interrupt request to the core.

Function
REQ-015 Implemented CSRs and their write masks SHALL be:
- mstatus 0x300: MIE[3] and MPIE[7] writable; MPP[12:11] reads 2'b11; other bits 0.
- misa 0x301: read-only 0x40000100.
- mie 0x304: bits 3, 7 and 11 writable.
- mtvec 0x305: bits [31:2] writable; [1:0] read 0.
- mscratch 0x340: full width.
- mepc 0x341: bits [31:2] writable; [1:0] read 0.
- mcause 0x342 and mtval 0x343: full width.
- mip 0x344: bit 11 = irq_ext; read-only.
REQ-016 Counter CSRs SHALL be:
- mcycle 0xB00 and mcycleh 0xB80: 64-bit cycle counter, read/write.
- minstret 0xB02 and minstreth 0xB82: 64-bit retired-instruction counter, read/write.
- 0xC00, 0xC80, 0xC02 and 0xC82: read-only shadows of the four counters above.
- 0xF11 to 0xF14: read-only, value 0.
REQ-017 csr_rd SHALL present the addressed register in the same cycle; csr_ra=0x000 SHALL return 0 with no error (idle address).
REQ-018 A write SHALL take effect at the rising edge with csr_we=1, and SHALL be readable the next cycle.
REQ-019 csr_err SHALL be 1 when csr_ra is nonzero and unimplemented.
REQ-020 csr_err SHALL be 1 when csr_we=1 and csr_wa is unimplemented, or csr_wa[11:10]=2'b11, or csr_wa=0x301 or 0x344.
REQ-021 An erroring write SHALL leave all state unchanged.
REQ-022 mcycle SHALL increment by 1 every cycle out of reset, carrying into mcycleh and wrapping from 2^64-1 to 0.
REQ-023 minstret SHALL increment by 1 in each cycle with retire=1, using the same carry and wrap rules.
REQ-024 A write to a counter half SHALL load csr_wd into that half with no increment that cycle; the other half SHALL keep counting, including any carry.
REQ-025 trap=1 SHALL capture the following in one cycle:
- mepc <= {trap_pc[31:2], 2'b00}
- mcause <= trap_cause
- mtval <= trap_val
- MPIE <= MIE
- MIE <= 0
REQ-026 mret=1 SHALL set MIE <= MPIE and MPIE <= 1.
REQ-027 If trap and mret are both 1 in the same cycle, trap SHALL win.
REQ-028 If trap or mret coincides with a CSR write to mstatus, mepc, mcause or mtval, the trap/mret update SHALL win for the fields it touches; writes to other CSRs SHALL proceed.
REQ-029 irq_pending SHALL equal MIE & mie[11] & irq_ext, combinationally.
REQ-030 mtvec_o and mepc_o SHALL reflect the register contents (registered values).

Reset
REQ-031 On rst_n=0, all writable CSRs and counters SHALL clear to 0 asynchronously, so mstatus reads 0x00001800.
REQ-032 During and immediately after reset, outputs SHALL be csr_rd=0 (for csr_ra=0), csr_err=0, irq_pending=0, mtvec_o=0 and mepc_o=0.
REQ-033 Counting SHALL start on the first rising edge with rst_n=1.
REQ-034 Reset asserted mid-operation SHALL abort any pending write and trap.

Verification
REQ-035 Write 0xDEADBEEF to 0x340, then set csr_ra=0x340 -> csr_rd=0xDEADBEEF the next cycle, csr_err=0 throughout.
REQ-036 Write 0xFFFFFFFF to 0x305 -> reads 0xFFFFFFFC; write to 0xC00 -> csr_err=1 and the counter is not disturbed.
REQ-037 Write mcycle=0xFFFFFFFE and mcycleh=5 -> after 2 cycles, mcycle=0 and mcycleh=6.
REQ-038 Set MIE=1, then trap with pc=0x1003, cause=0x8000000B, val=0x55 -> the following holds:
- mepc_o=0x1000
- mstatus=0x1880
- mcause=0x8000000B
- mtval=0x55
Then mret -> mstatus=0x1888.
REQ-039 Set mie=0x800 and MIE=1, raise irq_ext -> irq_pending=1 in the same cycle; clear MIE -> irq_pending=0.
REQ-040 Pulse rst_n low mid-count -> mcycle, minstret and mscratch read 0 and csr_err=0.
